// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the ramstate_t request handshake.
// Stores 2^DEPTH_W words. A legal read or write request is answered after LAT
// BUSY cycles with a single ACCESS cycle. Illegal requests get a single ERROR
// cycle. All outputs are registered.
//
// Ports:
//   CLK       rising-edge clock
//   nRST      synchronous active-low reset; clears state, ramload and storage
//   ramREN    read request (level, held by requester until ACCESS/ERROR)
//   ramWEN    write request (level, held by requester until ACCESS/ERROR)
//   ramaddr   byte address; the word index is ramaddr[DEPTH_W+1:2]
//   ramstore  write data
//   ramload   read data; updated only in a read's ACCESS cycle, held otherwise
//   ramstate  FREE / BUSY / ACCESS / ERROR

package ram_responder_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned LAT     = 2,
  parameter int unsigned DEPTH_W = 6
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            addr_q, data_q;
  logic             wr_q;
  word_t            mem [DEPTH];
  ramstate_t        ramstate_d;

  logic               req_c, illegal_c, same_c;
  logic               capture_c, commit_c;
  logic               from_in_c, acc_wr_c;
  logic [DEPTH_W-1:0] acc_idx_c;
  word_t              acc_data_c;

  // Request classification against the live inputs and the latched request.
  always_comb begin
    req_c     = ramREN | ramWEN;
    illegal_c = req_c && ((ramREN && ramWEN) ||
                          (ramaddr[1:0] != 2'b00) ||
                          ((ramaddr >> (DEPTH_W + 2)) != '0));
    same_c    = (ramREN ^ ramWEN) && (ramWEN == wr_q) && (ramaddr == addr_q);
  end

  // With LAT=0 the access happens on the same edge the request is seen in IDLE,
  // so the operands come straight from the inputs rather than the latches.
  always_comb begin
    from_in_c  = (state_q == IDLE);
    acc_wr_c   = from_in_c ? ramWEN : wr_q;
    acc_idx_c  = from_in_c ? ramaddr[DEPTH_W+1:2] : addr_q[DEPTH_W+1:2];
    acc_data_c = from_in_c ? ramstore : data_q;
  end

  // Next-state, counter and access control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (illegal_c) begin
          state_d = ERR;
        end else if (req_c) begin
          capture_c = 1'b1;
          cnt_d     = LAT_C;
          if (LAT_C != '0) begin
            state_d = WAIT;
          end else begin
            state_d  = DONE;
            commit_c = 1'b1;
          end
        end
      end
      WAIT: begin
        if (illegal_c) begin
          state_d = ERR;
          cnt_d   = '0;
        end else if (!same_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d  = DONE;
          commit_c = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake encoding of the state being entered, so ramstate is a flop.
  always_comb begin
    ramstate_d = FREE;
    unique case (state_d)
      IDLE:    ramstate_d = FREE;
      WAIT:    ramstate_d = BUSY;
      DONE:    ramstate_d = ACCESS;
      ERR:     ramstate_d = ERROR;
      default: ramstate_d = FREE;
    endcase
  end

  // State, request latches, storage and read data.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ramstate <= FREE;
      ramload  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[DEPTH_W'(i)] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ramstate <= ramstate_d;
      cnt_q    <= cnt_d;
      if (capture_c) begin
        addr_q <= ramaddr;
        data_q <= ramstore;
        wr_q   <= ramWEN;
      end
      if (commit_c) begin
        if (acc_wr_c) begin
          mem[acc_idx_c] <= acc_data_c;
        end else begin
          ramload <= mem[acc_idx_c];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: one instance with LAT=2 and one with
// LAT=0. Expected state/load per cycle are queued at stimulus time from a
// storage model and compared as each cycle completes.

module tb_ram_responder;
  import ram_responder_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  logic      ren0, wen0;
  word_t     addr0, store0, load0;
  ramstate_t state0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    ramstate_t st;
    word_t     ld;
  } exp_t;

  exp_t  sb[$];
  exp_t  sb0[$];
  word_t model [64];
  word_t ld_m;
  word_t ld0_m;

  ram_responder #(.LAT(2), .DEPTH_W(6)) dut (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  ram_responder #(.LAT(0), .DEPTH_W(6)) dut0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren0), .ramWEN(wen0),
    .ramaddr(addr0), .ramstore(store0), .ramload(load0), .ramstate(state0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic ren, input logic wen, input word_t a, input word_t d);
    ramREN = ren; ramWEN = wen; ramaddr = a; ramstore = d;
  endtask

  task automatic push(input ramstate_t st, input word_t ld);
    exp_t e;
    e.st = st; e.ld = ld;
    sb.push_back(e);
  endtask

  task automatic push0(input ramstate_t st, input word_t ld);
    exp_t e;
    e.st = st; e.ld = ld;
    sb0.push_back(e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = '0;
    ld_m  = '0;
    ld0_m = '0;
  endtask

  // Full LAT=2 read: BUSY, BUSY, ACCESS with stored word, FREE.
  task automatic push_read(input word_t a);
    word_t nv;
    nv = model[a[7:2]];
    push(BUSY, ld_m); push(BUSY, ld_m); push(ACCESS, nv); push(FREE, nv);
    ld_m = nv;
  endtask

  task automatic push_write(input word_t a, input word_t d);
    push(BUSY, ld_m); push(BUSY, ld_m); push(ACCESS, ld_m); push(FREE, ld_m);
    model[a[7:2]] = d;
  endtask

  task automatic test_reset();
    exp_t e;
    nRST = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    ren0 = 1'b0; wen0 = 1'b0; addr0 = '0; store0 = '0;
    clear_model();
    push(FREE, '0); push(FREE, '0); push(FREE, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (i == 1) nRST = 1'b1;
      e = sb.pop_front(); checks++;
      if (ramstate !== e.st || ramload !== e.ld) begin
        failures++;
        $display("FAIL reset step%0d: state=%0d load=%h, expected state=%0d load=%h",
                 i, ramstate, ramload, e.st, e.ld);
      end
    end
    checks++;
    if (state0 !== FREE || load0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_lat0: state=%0d load=%h, expected state=%0d load=0", state0, load0, FREE);
    end
  endtask

  // Write then read back, including the highest legal word.
  task automatic test_write_read();
    exp_t  e;
    word_t a, d;
    logic  wr;
    for (int t = 0; t < 4; t++) begin
      wr = (t == 0 || t == 2);
      a  = (t < 2) ? 32'h10 : 32'hFC;
      d  = (t < 2) ? 32'hDEADBEEF : 32'hA5A5_5A5A;
      if (wr) push_write(a, d);
      else    push_read(a);
      drive(!wr, wr, a, d);
      for (int i = 0; i < 4; i++) begin
        @(posedge CLK); #1;
        if (i == 2) drive(1'b0, 1'b0, '0, '0);
        e = sb.pop_front(); checks++;
        if (ramstate !== e.st || ramload !== e.ld) begin
          failures++;
          $display("FAIL write_read t%0d step%0d: state=%0d load=%h, expected state=%0d load=%h",
                   t, i, ramstate, ramload, e.st, e.ld);
        end
      end
    end
  endtask

  // Illegal requests: both ops, misaligned, out of range (read and write).
  task automatic test_illegal();
    exp_t  e;
    word_t a;
    logic  r, w;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0:       begin r = 1'b1; w = 1'b1; a = 32'h4;   end
        1:       begin r = 1'b1; w = 1'b0; a = 32'h102; end
        2:       begin r = 1'b1; w = 1'b0; a = 32'h100; end
        default: begin r = 1'b0; w = 1'b1; a = 32'h104; end
      endcase
      push(ERROR, ld_m); push(FREE, ld_m);
      drive(r, w, a, 32'h5555_1111);
      for (int i = 0; i < 2; i++) begin
        @(posedge CLK); #1;
        if (i == 0) drive(1'b0, 1'b0, '0, '0);
        e = sb.pop_front(); checks++;
        if (ramstate !== e.st || ramload !== e.ld) begin
          failures++;
          $display("FAIL illegal t%0d step%0d: state=%0d load=%h, expected state=%0d load=%h",
                   t, i, ramstate, ramload, e.st, e.ld);
        end
      end
    end
    push_read(32'h4);
    drive(1'b1, 1'b0, 32'h4, '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (i == 2) drive(1'b0, 1'b0, '0, '0);
      e = sb.pop_front(); checks++;
      if (ramstate !== e.st || ramload !== e.ld) begin
        failures++;
        $display("FAIL illegal_readback step%0d: state=%0d load=%h, expected state=%0d load=%h",
                 i, ramstate, ramload, e.st, e.ld);
      end
    end
  endtask

  // Aborts from WAIT: address change, op change, deassert.
  task automatic test_abort();
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      push(BUSY, ld_m); push(FREE, ld_m); push(FREE, ld_m);
      drive(1'b0, 1'b1, 32'h8, 32'h1234);
      for (int i = 0; i < 3; i++) begin
        @(posedge CLK); #1;
        if (i == 0) begin
          case (t)
            0:       drive(1'b0, 1'b1, 32'hC, 32'h1234);
            1:       drive(1'b1, 1'b0, 32'h8, 32'h1234);
            default: drive(1'b0, 1'b0, 32'h8, 32'h1234);
          endcase
        end
        if (i == 1) drive(1'b0, 1'b0, '0, '0);
        e = sb.pop_front(); checks++;
        if (ramstate !== e.st || ramload !== e.ld) begin
          failures++;
          $display("FAIL abort t%0d step%0d: state=%0d load=%h, expected state=%0d load=%h",
                   t, i, ramstate, ramload, e.st, e.ld);
        end
      end
    end
    for (int t = 0; t < 2; t++) begin
      push_read(t == 0 ? 32'h8 : 32'hC);
      drive(1'b1, 1'b0, t == 0 ? 32'h8 : 32'hC, '0);
      for (int i = 0; i < 4; i++) begin
        @(posedge CLK); #1;
        if (i == 2) drive(1'b0, 1'b0, '0, '0);
        e = sb.pop_front(); checks++;
        if (ramstate !== e.st || ramload !== e.ld) begin
          failures++;
          $display("FAIL abort_readback t%0d step%0d: state=%0d load=%h, expected state=%0d load=%h",
                   t, i, ramstate, ramload, e.st, e.ld);
        end
      end
    end
  endtask

  // Request held past ACCESS starts a fresh transaction after one FREE cycle.
  task automatic test_back_to_back();
    exp_t e;
    push(BUSY, ld_m); push(BUSY, ld_m); push(ACCESS, ld_m);
    push(FREE, ld_m); push(BUSY, ld_m); push(FREE, ld_m);
    model[12] = 32'h0000CAFE;
    drive(1'b0, 1'b1, 32'h30, 32'h0000CAFE);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (i == 4) drive(1'b0, 1'b0, '0, '0);
      e = sb.pop_front(); checks++;
      if (ramstate !== e.st || ramload !== e.ld) begin
        failures++;
        $display("FAIL back_to_back step%0d: state=%0d load=%h, expected state=%0d load=%h",
                 i, ramstate, ramload, e.st, e.ld);
      end
    end
  endtask

  // Reset during BUSY (first and last BUSY cycle) aborts without a write.
  task automatic test_reset_mid();
    exp_t  e;
    word_t a;
    push_read(32'h10);
    drive(1'b1, 1'b0, 32'h10, '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (i == 2) drive(1'b0, 1'b0, '0, '0);
      e = sb.pop_front(); checks++;
      if (ramstate !== e.st || ramload !== e.ld) begin
        failures++;
        $display("FAIL reset_mid_pre step%0d: state=%0d load=%h, expected state=%0d load=%h",
                 i, ramstate, ramload, e.st, e.ld);
      end
    end
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i <= t; i++) push(BUSY, ld_m);
      clear_model();
      push(FREE, '0); push(FREE, '0);
      drive(1'b0, 1'b1, t == 0 ? 32'h20 : 32'h24, t == 0 ? 32'hFFFF : 32'h77);
      for (int i = 0; i < t + 3; i++) begin
        @(posedge CLK); #1;
        if (i == t) nRST = 1'b0;
        if (i == t + 1) begin
          nRST = 1'b1;
          drive(1'b0, 1'b0, '0, '0);
        end
        e = sb.pop_front(); checks++;
        if (ramstate !== e.st || ramload !== e.ld) begin
          failures++;
          $display("FAIL reset_mid t%0d step%0d: state=%0d load=%h, expected state=%0d load=%h",
                   t, i, ramstate, ramload, e.st, e.ld);
        end
      end
    end
    for (int t = 0; t < 4; t++) begin
      case (t)
        0:       a = 32'h20;
        1:       a = 32'h24;
        2:       a = 32'h10;
        default: a = 32'h30;
      endcase
      push_read(a);
      drive(1'b1, 1'b0, a, '0);
      for (int i = 0; i < 4; i++) begin
        @(posedge CLK); #1;
        if (i == 2) drive(1'b0, 1'b0, '0, '0);
        e = sb.pop_front(); checks++;
        if (ramstate !== e.st || ramload !== e.ld) begin
          failures++;
          $display("FAIL reset_readback t%0d step%0d: state=%0d load=%h, expected state=%0d load=%h",
                   t, i, ramstate, ramload, e.st, e.ld);
        end
      end
    end
  endtask

  // LAT=0 instance: ACCESS on the first cycle, never BUSY.
  task automatic test_lat0();
    exp_t e;
    push0(ACCESS, ld0_m); push0(FREE, ld0_m); push0(ACCESS, ld0_m);
    push0(FREE, ld0_m); push0(FREE, ld0_m);
    push0(ACCESS, ld0_m); push0(FREE, ld0_m);
    push0(ACCESS, 32'hA5); push0(FREE, 32'hA5);
    ren0 = 1'b1; wen0 = 1'b0; addr0 = 32'h0; store0 = '0;
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      if (i == 3) ren0 = 1'b0;
      if (i == 4) begin wen0 = 1'b1; addr0 = 32'h4; store0 = 32'hA5; end
      if (i == 5) begin wen0 = 1'b0; store0 = '0; end
      if (i == 6) ren0 = 1'b1;
      if (i == 7) ren0 = 1'b0;
      e = sb0.pop_front(); checks++;
      if (state0 !== e.st || load0 !== e.ld) begin
        failures++;
        $display("FAIL lat0 step%0d: state=%0d load=%h, expected state=%0d load=%h",
                 i, state0, load0, e.st, e.ld);
      end
    end
    ld0_m = 32'hA5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_lat0();
    if (sb.size() != 0 || sb0.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d/%0d, expected 0/0", sb.size(), sb0.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter: LAT, 2, BUSY cycles before ACCESS; legal range 0..15.
REQ-002 Parameter: DEPTH_W, 6, log2 of storage depth in words (64 words).
REQ-003 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: nRST  input  1  reset, synchronous, active-low.
REQ-005 Port: ramREN  input  1  read request, level, held by requester until ACCESS or ERROR.
REQ-006 Port: ramWEN  input  1  write request, level, held by requester until ACCESS or ERROR.
REQ-007 Port: ramaddr  input  32 (word_t)  byte address.
REQ-008 Port: ramstore  input  32 (word_t)  write data.
REQ-009 Port: ramload  output  32 (word_t)  read data.
REQ-010 Port: ramstate  output  2 (ramstate_t)  FREE/BUSY/ACCESS/ERROR.

Function
REQ-011 Block SHALL be the memory-side responder of the ramstate_t handshake: storage of 2^DEPTH_W words, registered outputs.
REQ-012 FSM states SHALL be IDLE, WAIT, DONE, ERR; ramstate SHALL be FREE, BUSY, ACCESS, ERROR respectively.
REQ-013 IDLE with no request SHALL stay IDLE.
REQ-014 Request is illegal if ramREN&ramWEN, ramaddr[1:0]!=0, or ramaddr[31:DEPTH_W+2]!=0; an illegal request seen in IDLE or WAIT SHALL go to ERR next cycle.
REQ-015 Legal request in IDLE SHALL latch ramaddr, op, ramstore; load 4-bit counter with LAT; go to WAIT if LAT>0, else DONE.
REQ-016 WAIT SHALL decrement counter each cycle; go to DONE when counter reaches 1 and request unchanged; ACCESS therefore first appears LAT+1 cycles after the request's first cycle.
REQ-017 In WAIT, if request deasserts, ramaddr differs from latched address, or op changes, SHALL return to IDLE (abort), no storage change.
REQ-018 DONE SHALL last exactly one cycle; write SHALL commit latched ramstore to storage at entry to DONE; read SHALL drive ramload with stored word for that cycle.
REQ-019 ramload SHALL hold its last value outside DONE (not cleared).
REQ-020 After DONE SHALL go to IDLE; a still-asserted request is treated as a new transaction starting the following cycle (no back-to-back ACCESS).
REQ-021 ERR SHALL last one cycle then go to IDLE; no storage write on any ERROR path.
REQ-022 Read of an address written in a previous transaction SHALL return the written data; storage word index = ramaddr[DEPTH_W+1:2].
REQ-023 Counter SHALL not wrap; LAT=0 yields BUSY never asserted.

Reset
REQ-024 nRST low at a rising edge SHALL force IDLE, ramstate=FREE, ramload=0, counter=0, and clear all storage to 0.
REQ-025 Reset asserted in WAIT or DONE SHALL abort the transaction with no write committed on that edge.
REQ-026 Reset has priority over every request input.

Verification
REQ-027 LAT=2: WEN addr 0x10 data 0xDEADBEEF held -> BUSY,BUSY,ACCESS on cycles 1..3 then FREE; later REN 0x10 -> ACCESS with ramload=0xDEADBEEF.
REQ-028 REN and WEN both high, addr 0x4 -> ERROR next cycle, FREE after; read of 0x4 returns 0.
REQ-029 REN addr 0x102 (misaligned) and addr 0x100 (out of range, DEPTH_W=6) -> ERROR each, no storage change.
REQ-030 WEN 0x8 data 0x1234, ramaddr changed to 0xC mid-BUSY -> FREE next cycle; read 0x8 returns 0.
REQ-031 nRST low during BUSY of WEN 0x20 data 0xFFFF -> FREE, ramload=0; read 0x20 after release returns 0.
REQ-032 LAT=0: REN 0x0 held 4 cycles -> ACCESS,FREE,ACCESS,FREE pattern, never BUSY.
